// File: rtl/gen_gamma_seq.sv
// Gamma coder sequencer: loads the coder, steps it only when a buffer
// slot is guaranteed, and streams captured words through a 3-deep FIFO.
module gen_gamma_seq #(
    parameter int SIZE  = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [SIZE-1:0]  seed,
    input  logic [CNT_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic [SIZE-1:0]  coder_id,
    output logic             coder_set0,
    output logic             coder_set1,
    output logic             coder_en,
    input  logic [SIZE-1:0]  coder_nk,
    output logic [SIZE-1:0]  g_data,
    output logic             g_valid,
    input  logic             g_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD0,
        S_LOAD1,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_len;
    logic [CNT_W-1:0] r_issued;
    logic [CNT_W-1:0] r_captured;
    logic [SIZE-1:0]  r_id;
    logic [SIZE-1:0]  r_mem [3];
    logic [1:0]       r_count;
    logic [1:0]       r_wr;
    logic [1:0]       r_rd;
    logic             r_busy;
    logic             r_done;
    logic             r_set0;
    logic             r_set1;
    logic             r_en;
    logic             r_en_q;

    logic             w_push;
    logic             w_pop;
    logic [1:0]       w_count_nxt;
    logic             w_issue;
    logic             w_drained;

    function automatic logic [1:0] inc3(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    assign w_push      = r_en_q;
    assign w_pop       = g_valid & g_ready;
    assign w_count_nxt = r_count + {1'b0, w_push} - {1'b0, w_pop};

    // Next-cycle enable: words already buffered plus the one in flight
    // must leave room for the word this enable will produce.
    assign w_issue = (r_state == S_LOAD1 || r_state == S_RUN)
                   && (r_issued != r_len)
                   && (({1'b0, w_count_nxt} + {2'b00, r_en}) < 3'd3);

    assign w_drained = (r_captured == r_len) && !r_en_q
                     && (w_count_nxt == 2'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_len      <= '0;
            r_issued   <= '0;
            r_captured <= '0;
            r_id       <= '0;
            r_count    <= '0;
            r_wr       <= '0;
            r_rd       <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_set0     <= 1'b0;
            r_set1     <= 1'b0;
            r_en       <= 1'b0;
            r_en_q     <= 1'b0;
            for (int i = 0; i < 3; i++) r_mem[i] <= '0;
        end else if (abort) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_wr    <= '0;
            r_rd    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_set0  <= 1'b0;
            r_set1  <= 1'b0;
            r_en    <= 1'b0;
            r_en_q  <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_en_q  <= r_en;
            r_en    <= w_issue;
            r_count <= w_count_nxt;
            if (w_push) begin
                r_mem[r_wr] <= coder_nk;
                r_wr        <= inc3(r_wr);
                r_captured  <= r_captured + CNT_W'(1);
            end
            if (w_pop) r_rd <= inc3(r_rd);
            if (w_issue) r_issued <= r_issued + CNT_W'(1);
            unique case (r_state)
                S_IDLE: begin
                    if (start && len != '0) begin
                        r_len      <= len;
                        r_id       <= seed;
                        r_issued   <= '0;
                        r_captured <= '0;
                        r_busy     <= 1'b1;
                        r_set0     <= 1'b1;
                        r_state    <= S_LOAD0;
                    end else if (start) begin
                        r_done <= 1'b1;
                    end
                end
                S_LOAD0: begin
                    r_set1  <= 1'b1;
                    r_state <= S_LOAD1;
                end
                S_LOAD1: begin
                    r_set0  <= 1'b0;
                    r_set1  <= 1'b0;
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    if (r_issued == r_len) r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (w_drained) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign coder_id   = r_id;
    assign coder_set0 = r_set0;
    assign coder_set1 = r_set1;
    assign coder_en   = r_en;
    assign g_valid    = (r_count != 2'd0);
    assign g_data     = r_mem[r_rd];

endmodule

// File: tb/tb_gen_gamma_seq.sv
// Directed bench for gen_gamma_seq with a behavioural gamma coder
// (load seed, xor-mix on set1, affine step on en, one-cycle latency).
module tb_gen_gamma_seq;

    localparam int SIZE  = 8;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             g_ready = 1'b0;
    logic [SIZE-1:0]  seed = '0;
    logic [CNT_W-1:0] len = '0;
    logic             busy;
    logic             done;
    logic [SIZE-1:0]  coder_id;
    logic             coder_set0;
    logic             coder_set1;
    logic             coder_en;
    logic [SIZE-1:0]  coder_nk;
    logic [SIZE-1:0]  g_data;
    logic             g_valid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gen_gamma_seq #(.SIZE(SIZE), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .seed       (seed),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .coder_id   (coder_id),
        .coder_set0 (coder_set0),
        .coder_set1 (coder_set1),
        .coder_en   (coder_en),
        .coder_nk   (coder_nk),
        .g_data     (g_data),
        .g_valid    (g_valid),
        .g_ready    (g_ready)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) coder_nk <= '0;
        else if (coder_set0 && coder_set1) coder_nk <= coder_nk ^ 8'h3C;
        else if (coder_set0) coder_nk <= coder_id;
        else if (coder_en) coder_nk <= coder_nk * 8'd5 + 8'd1;
    end

    function automatic logic [7:0] exp_word(input logic [7:0] s, input int k);
        logic [7:0] v;
        v = s ^ 8'h3C;
        for (int i = 0; i <= k; i++) v = v * 8'd5 + 8'd1;
        return v;
    endfunction

    task automatic test_reset();
        logic [21:0] v;
        #2;
        v = {busy, done, coder_set0, coder_set1, coder_en, g_valid,
             coder_id, g_data};
        checks++;
        if (v !== 22'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", v);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        v = {busy, done, coder_set0, coder_set1, coder_en, g_valid,
             coder_id, g_data};
        checks++;
        if (v !== 22'd0) begin
            errors++;
            $display("FAIL reset_idle: got %h expected 0", v);
        end
    endtask

    task automatic test_basic();
        logic [7:0] ew [4];
        logic [5:0] got;
        logic [5:0] want;
        ew[0] = 8'hFF;
        ew[1] = 8'hFC;
        ew[2] = 8'hED;
        ew[3] = 8'hA2;
        @(negedge clk);
        seed = 8'h5A;
        len = 16'd4;
        g_ready = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        seed = 8'hFF;
        len = 16'd99;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            got = {busy, done, coder_set0, coder_set1, coder_en, g_valid};
            want = {c >= 1 && c <= 8, c == 9, c <= 2, c == 2,
                    c >= 3 && c <= 6, c >= 5 && c <= 8};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL basic_ctl c%0d: got %b expected %b",
                         c, got, want);
            end
            if (c >= 5 && c <= 8) begin
                checks++;
                if (g_data !== ew[c-5]) begin
                    errors++;
                    $display("FAIL basic_data c%0d: got %h expected %h",
                             c, g_data, ew[c-5]);
                end
            end
            if (c <= 8) begin
                checks++;
                if (coder_id !== 8'h5A) begin
                    errors++;
                    $display("FAIL basic_id c%0d: got %h expected 5a",
                             c, coder_id);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int c = 0;
        int got = 0;
        int occ = 0;
        int enq = 0;
        int dn = 0;
        logic pop;
        @(negedge clk);
        seed = 8'h11;
        len = 16'd10;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        while (dn == 0 && c < 300) begin
            @(negedge clk);
            c++;
            g_ready = (c >= 12 && c <= 17) ? 1'b0 : c[0];
            checks++;
            if (coder_en && (occ + enq >= 3)) begin
                errors++;
                $display("FAIL bp_en_limit c%0d: got en=1 with %0d", c,
                         occ + enq);
            end
            checks++;
            if (g_valid !== (occ != 0) || occ > 3) begin
                errors++;
                $display("FAIL bp_valid c%0d: got %b expected occ %0d",
                         c, g_valid, occ);
            end
            pop = g_valid && g_ready;
            if (pop) begin
                checks++;
                if (g_data !== exp_word(8'h11, got)) begin
                    errors++;
                    $display("FAIL bp_data w%0d: got %h expected %h", got,
                             g_data, exp_word(8'h11, got));
                end
                got++;
            end
            if (done) dn = 1;
            occ = occ + enq - int'(pop);
            enq = int'(coder_en);
        end
        checks++;
        if (got != 10 || dn != 1) begin
            errors++;
            $display("FAIL bp_count: got %0d words done=%0d expected 10/1",
                     got, dn);
        end
        g_ready = 1'b1;
    endtask

    task automatic test_zero_len();
        logic [4:0] v;
        @(negedge clk);
        seed = 8'hAB;
        len = 16'd0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            v = {busy, coder_set0, coder_set1, coder_en, g_valid};
            checks++;
            if (v !== 5'd0 || done !== (c == 1)) begin
                errors++;
                $display("FAIL zero_len c%0d: got %b done=%b expected 0/%0d",
                         c, v, done, c == 1);
            end
        end
    endtask

    task automatic test_abort();
        int c = 0;
        int got = 0;
        int dn = 0;
        logic [5:0] v;
        @(negedge clk);
        seed = 8'h77;
        len = 16'd20;
        g_ready = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        while (got < 5 && c < 100) begin
            @(negedge clk);
            c++;
            if (g_valid) begin
                checks++;
                if (g_data !== exp_word(8'h77, got)) begin
                    errors++;
                    $display("FAIL abort_data w%0d: got %h expected %h", got,
                             g_data, exp_word(8'h77, got));
                end
                got++;
            end
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        v = {busy, done, coder_set0, coder_set1, coder_en, g_valid};
        checks++;
        if (v !== 6'd0 || got != 5) begin
            errors++;
            $display("FAIL abort_next: got %b after %0d words expected 0/5",
                     v, got);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL abort_quiet: got done=%b busy=%b expected 0",
                         done, busy);
            end
        end
        seed = 8'h21;
        len = 16'd2;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        got = 0;
        c = 0;
        while (dn == 0 && c < 50) begin
            @(negedge clk);
            c++;
            if (g_valid) begin
                checks++;
                if (g_data !== exp_word(8'h21, got)) begin
                    errors++;
                    $display("FAIL abort_restart w%0d: got %h expected %h",
                             got, g_data, exp_word(8'h21, got));
                end
                got++;
            end
            if (done) dn = 1;
        end
        checks++;
        if (got != 2 || dn != 1) begin
            errors++;
            $display("FAIL abort_restart_cnt: got %0d/%0d expected 2/1",
                     got, dn);
        end
    endtask

    task automatic test_async_reset();
        logic [21:0] v;
        @(negedge clk);
        seed = 8'h5A;
        len = 16'd4;
        g_ready = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        v = {busy, done, coder_set0, coder_set1, coder_en, g_valid,
             coder_id, g_data};
        checks++;
        if (v !== 22'd0) begin
            errors++;
            $display("FAIL async_reset: got %h expected 0", v);
        end
        #2;
        rst_n = 1'b1;
        test_basic();
    endtask

    task automatic test_start_busy();
        int c = 0;
        int got = 0;
        int dn = 0;
        @(negedge clk);
        seed = 8'h42;
        len = 16'd3;
        g_ready = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        while (dn == 0 && c < 50) begin
            @(negedge clk);
            c++;
            start = (c == 4);
            if (c == 4) begin
                seed = 8'h99;
                len = 16'd7;
            end
            if (g_valid) begin
                checks++;
                if (g_data !== exp_word(8'h42, got)) begin
                    errors++;
                    $display("FAIL busy_start w%0d: got %h expected %h", got,
                             g_data, exp_word(8'h42, got));
                end
                got++;
            end
            if (done) dn = 1;
        end
        start = 1'b0;
        checks++;
        if (got != 3 || dn != 1) begin
            errors++;
            $display("FAIL busy_start_cnt: got %0d/%0d expected 3/1",
                     got, dn);
        end
        @(negedge clk);
        len = 16'd5;
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({busy, done, coder_set0} !== 3'd0) begin
                errors++;
                $display("FAIL start_abort: got %b expected 000",
                         {busy, done, coder_set0});
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_len();
        test_abort();
        test_async_reset();
        test_start_busy();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
